// File: rtl/enigma_ctrl_if.sv
// Stream and configuration handshakes between the host side and enigma_ctrl.
// Master drives requests and payloads; slave answers with ready/valid.
interface enigma_ctrl_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [14:0] cfg_key;
    logic [1:0]  cfg_rA;
    logic [1:0]  cfg_rB;
    logic [1:0]  cfg_rC;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    modport master (
        output cfg_valid, cfg_key, cfg_rA, cfg_rB, cfg_rC,
        output in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_valid, cfg_key, cfg_rA, cfg_rB, cfg_rC,
        input  in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/enigma_ctrl.sv
// Sequencer between an ASCII byte stream and an external Enigma rotor datapath.
// Handles key loading, rotor step pulses, settle timing and output handshake.
module enigma_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          PASS_NONALPHA = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    enigma_ctrl_if.slave bus,
    output logic [4:0]   e_char_in,
    output logic [14:0]  e_key,
    output logic [1:0]   e_rA_cfg,
    output logic [1:0]   e_rB_cfg,
    output logic [1:0]   e_rC_cfg,
    output logic         e_load_key,
    output logic         e_new_char,
    input  logic [4:0]   e_char_out,
    output logic         busy,
    output logic         cfg_err,
    output logic         char_err,
    output logic [15:0]  char_count
);
    typedef enum logic [2:0] {IDLE, LOAD, STEP, SETTLE, OUT} state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic        loaded_q;
    logic        letter_q;
    logic [3:0]  cnt_q;
    logic [4:0]  char_q;
    logic [14:0] key_q;
    logic [1:0]  ra_q, rb_q, rc_q;
    logic        load_q, step_q, cerr_q, herr_q;
    logic        ov_q;
    logic [7:0]  od_q;
    logic [15:0] count_q, count_d;

    logic       idle, cfg_acc, in_acc, out_acc;
    logic       cfg_bad, is_up, is_lo, is_letter;
    logic [4:0] char_d;

    assign idle    = (state_q == IDLE);
    assign cfg_acc = idle && bus.cfg_valid;
    assign in_acc  = idle && loaded_q && bus.in_valid && !bus.cfg_valid;
    assign out_acc = ov_q && bus.out_ready;

    assign cfg_bad = (bus.cfg_rA == 2'd3) || (bus.cfg_rB == 2'd3)
                  || (bus.cfg_rC == 2'd3)
                  || (bus.cfg_key[4:0] > 5'd25)
                  || (bus.cfg_key[9:5] > 5'd25)
                  || (bus.cfg_key[14:10] > 5'd25);

    assign is_up     = (bus.in_data >= 8'h41) && (bus.in_data <= 8'h5A);
    assign is_lo     = (bus.in_data >= 8'h61) && (bus.in_data <= 8'h7A);
    assign is_letter = is_up || is_lo;
    // Both cases share low bits: 'A' and 'a' both end in 5'd1.
    assign char_d    = bus.in_data[4:0] - 5'd1;

    assign count_d = (letter_q && count_q != 16'hFFFF) ? count_q + 16'd1
                                                       : count_q;

    assign bus.cfg_ready = idle;
    assign bus.in_ready  = in_acc || (idle && loaded_q && !bus.cfg_valid);
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;

    assign e_char_in  = char_q;
    assign e_key      = key_q;
    assign e_rA_cfg   = ra_q;
    assign e_rB_cfg   = rb_q;
    assign e_rC_cfg   = rc_q;
    assign e_load_key = load_q;
    assign e_new_char = step_q;
    assign busy       = !idle;
    assign cfg_err    = cerr_q;
    assign char_err   = herr_q;
    assign char_count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            loaded_q <= 1'b0;
            letter_q <= 1'b0;
            cnt_q    <= 4'd0;
            char_q   <= 5'd0;
            key_q    <= 15'd0;
            ra_q     <= 2'd0;
            rb_q     <= 2'd1;
            rc_q     <= 2'd2;
            load_q   <= 1'b0;
            step_q   <= 1'b0;
            cerr_q   <= 1'b0;
            herr_q   <= 1'b0;
            ov_q     <= 1'b0;
            od_q     <= 8'd0;
            count_q  <= 16'd0;
        end else begin
            load_q <= 1'b0;
            step_q <= 1'b0;
            cerr_q <= 1'b0;
            herr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg_acc) begin
                        if (cfg_bad) begin
                            cerr_q <= 1'b1;
                        end else begin
                            key_q   <= bus.cfg_key;
                            ra_q    <= bus.cfg_rA;
                            rb_q    <= bus.cfg_rB;
                            rc_q    <= bus.cfg_rC;
                            load_q  <= 1'b1;
                            state_q <= LOAD;
                        end
                    end else if (in_acc) begin
                        if (is_letter) begin
                            char_q   <= char_d;
                            letter_q <= 1'b1;
                            step_q   <= 1'b1;
                            state_q  <= STEP;
                        end else if (PASS_NONALPHA) begin
                            od_q     <= bus.in_data;
                            ov_q     <= 1'b1;
                            letter_q <= 1'b0;
                            state_q  <= OUT;
                        end else begin
                            herr_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    loaded_q <= 1'b1;
                    count_q  <= 16'd0;
                    state_q  <= IDLE;
                end
                STEP: begin
                    cnt_q   <= SETTLE_INIT;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        od_q    <= 8'h41 + {3'b000, e_char_out};
                        ov_q    <= 1'b1;
                        state_q <= OUT;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                OUT: begin
                    if (out_acc) begin
                        ov_q    <= 1'b0;
                        count_q <= count_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enigma_ctrl.sv
// Bench for enigma_ctrl: three-rotor Enigma datapath model, scoreboard queue,
// directed sequences for load, cipher, passthrough, stalls, errors and reset.
module tb_enigma_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    enigma_ctrl_if bus ();
    enigma_ctrl_if bus2 ();

    logic [4:0]  e_char_in, e_char_out;
    logic [14:0] e_key;
    logic [1:0]  e_rA_cfg, e_rB_cfg, e_rC_cfg;
    logic        e_load_key, e_new_char, busy, cfg_err, char_err;
    logic [15:0] char_count;

    logic [4:0]  c2_ci;
    logic [14:0] c2_key;
    logic [1:0]  c2_ra, c2_rb, c2_rc;
    logic        c2_lk, c2_nc, c2_busy, c2_ce, c2_he;
    logic [15:0] c2_cnt;

    enigma_ctrl #(.SETTLE_CYCLES(2), .PASS_NONALPHA(1'b1)) u_dut (
        .clk(clk), .reset(reset), .bus(bus),
        .e_char_in(e_char_in), .e_key(e_key),
        .e_rA_cfg(e_rA_cfg), .e_rB_cfg(e_rB_cfg), .e_rC_cfg(e_rC_cfg),
        .e_load_key(e_load_key), .e_new_char(e_new_char),
        .e_char_out(e_char_out), .busy(busy), .cfg_err(cfg_err),
        .char_err(char_err), .char_count(char_count)
    );

    enigma_ctrl #(.SETTLE_CYCLES(2), .PASS_NONALPHA(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .e_char_in(c2_ci), .e_key(c2_key),
        .e_rA_cfg(c2_ra), .e_rB_cfg(c2_rb), .e_rC_cfg(c2_rc),
        .e_load_key(c2_lk), .e_new_char(c2_nc),
        .e_char_out(5'd0), .busy(c2_busy), .cfg_err(c2_ce),
        .char_err(c2_he), .char_count(c2_cnt)
    );

    string WIR [3] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ",
                       "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                       "BDFHJLCPRTXVZNYEAIUOKQSGWM"};
    string REFL = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    int NOTCH [3] = '{16, 4, 21};

    function automatic int fwd(int r, int p, int c);
        int x;
        x = (c + p) % 26;
        return (int'(WIR[r].getc(x)) - 65 - p + 52) % 26;
    endfunction

    function automatic int bwd(int r, int p, int c);
        int t, res;
        t = (c + p) % 26;
        res = 0;
        for (int j = 0; j < 26; j++)
            if (int'(WIR[r].getc(j)) - 65 == t) res = j;
        return (res - p + 26) % 26;
    endfunction

    function automatic int enc(int p0, int p1, int p2,
                               int t0, int t1, int t2, int c);
        int x;
        if (t0 > 2 || t1 > 2 || t2 > 2 || c > 25) return c;
        x = fwd(t0, p0, c);
        x = fwd(t1, p1, x);
        x = fwd(t2, p2, x);
        x = int'(REFL.getc(x)) - 65;
        x = bwd(t2, p2, x);
        x = bwd(t1, p1, x);
        x = bwd(t0, p0, x);
        return x;
    endfunction

    // Rotor advance with the middle-rotor double step.
    function automatic void stp(inout int p0, inout int p1, inout int p2,
                                input int t0, input int t1);
        if (p1 == NOTCH[t1]) begin
            p1 = (p1 + 1) % 26;
            p2 = (p2 + 1) % 26;
        end else if (p0 == NOTCH[t0]) begin
            p1 = (p1 + 1) % 26;
        end
        p0 = (p0 + 1) % 26;
    endfunction

    int dp0 = 0, dp1 = 0, dp2 = 0;
    always @(posedge clk) begin : dp_blk
        int a, b, c;
        a = dp0; b = dp1; c = dp2;
        if (e_load_key) begin
            a = int'(e_key[4:0]);
            b = int'(e_key[9:5]);
            c = int'(e_key[14:10]);
        end else if (e_new_char) begin
            stp(a, b, c, int'(e_rA_cfg), int'(e_rB_cfg));
        end
        dp0 <= a; dp1 <= b; dp2 <= c;
    end

    assign e_char_out = 5'(enc(dp0, dp1, dp2, int'(e_rA_cfg), int'(e_rB_cfg),
                               int'(e_rC_cfg), int'(e_char_in)));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int sb0 = 0, sb1 = 0, sb2 = 0, st0 = 0, st1 = 1, st2 = 2;
    logic [7:0] sbq [$];
    logic [7:0] cap [$];

    int lk_cyc = 0, nc_cyc = 0, ce_cyc = 0, overlap = 0, wide = 0;
    int unstable = 0, n_out = 0, ce2 = 0, ov2 = 0, nc2 = 0;
    bit prev_lk = 0, prev_nc = 0, prev_ce = 0, prev_he2 = 0, prev_stall = 0;
    logic [7:0] prev_od = 8'd0;

    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (e_load_key) lk_cyc++;
        if (e_new_char) nc_cyc++;
        if (cfg_err) ce_cyc++;
        if (e_load_key && e_new_char) overlap++;
        if ((e_load_key && prev_lk) || (e_new_char && prev_nc)) wide++;
        if ((cfg_err && prev_ce) || (c2_he && prev_he2)) wide++;
        prev_lk = e_load_key; prev_nc = e_new_char;
        prev_ce = cfg_err; prev_he2 = c2_he;
        if (prev_stall && bus.out_valid && bus.out_data != prev_od) unstable++;
        if (prev_stall && !bus.out_valid) unstable++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_od = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            cap.push_back(bus.out_data);
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'(bus.out_data), 32'hFFFF);
            end else begin
                e = sbq.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e));
            end
        end
        if (c2_he) ce2++;
        if (bus2.out_valid) ov2++;
        if (c2_nc) nc2++;
    end

    function automatic void sb_cfg(input logic [14:0] key,
                                   input logic [1:0] ra, rb, rc);
        if (ra == 3 || rb == 3 || rc == 3 || key[4:0] > 25 ||
            key[9:5] > 25 || key[14:10] > 25) return;
        sb0 = int'(key[4:0]); sb1 = int'(key[9:5]); sb2 = int'(key[14:10]);
        st0 = int'(ra); st1 = int'(rb); st2 = int'(rc);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_load(input logic [14:0] key,
                            input logic [1:0] ra, rb, rc);
        int n;
        bit ok;
        bus.cfg_key = key; bus.cfg_rA = ra; bus.cfg_rB = rb; bus.cfg_rC = rc;
        bus.cfg_valid = 1'b1;
        n = 0; ok = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            ok = bus.cfg_ready;
        end
        if (!ok) chk("cfg_acc_to", 0, 1);
        else sb_cfg(key, ra, rb, rc);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] c);
        int n, idx;
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_data = c;
        n = 0; ok = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            n++;
            ok = bus.in_ready;
        end
        if (!ok) begin
            chk("in_acc_to", 0, 1);
        end else if ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A)) begin
            idx = int'(c[4:0]) - 1;
            stp(sb0, sb1, sb2, st0, st1);
            sbq.push_back(8'h41 + 8'(enc(sb0, sb1, sb2, st0, st1, st2, idx)));
        end else begin
            sbq.push_back(c);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_to", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin : main
        int n, ir, lk0, nc0, ce0, cc0, no0;
        bit ok;
        string hello;
        logic [7:0] ct [5];
        hello = "HELLO";

        reset = 1'b1;
        bus.cfg_valid = 0; bus.cfg_key = 0;
        bus.cfg_rA = 0; bus.cfg_rB = 0; bus.cfg_rC = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1;
        bus2.cfg_valid = 0; bus2.cfg_key = 0;
        bus2.cfg_rA = 0; bus2.cfg_rB = 1; bus2.cfg_rC = 2;
        bus2.in_valid = 0; bus2.in_data = 0; bus2.out_ready = 1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("rst_cfg_rdy", bus.cfg_ready, 1);
        chk("rst_in_rdy", bus.in_ready, 0);
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_od", bus.out_data, 0);
        chk("rst_key", e_key, 0);
        chk("rst_ra", e_rA_cfg, 0);
        chk("rst_rb", e_rB_cfg, 1);
        chk("rst_rc", e_rC_cfg, 2);
        chk("rst_cnt", char_count, 0);
        chk("rst_busy", busy, 0);

        bus.in_valid = 1; bus.in_data = 8'h41;
        ir = 0; nc0 = nc_cyc;
        repeat (20) begin
            @(negedge clk);
            if (bus.in_ready) ir++;
        end
        chk("noload_ir", ir, 0);
        chk("noload_nc", nc_cyc - nc0, 0);
        @(posedge clk); #1;
        bus.in_valid = 0;

        lk0 = lk_cyc;
        cfg_load(15'd0, 2'd0, 2'd1, 2'd2);
        chk("load_pulse", lk_cyc - lk0, 1);
        chk("load_cnt", char_count, 0);

        nc0 = nc_cyc;
        send(8'h61);
        n = 0; ok = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("a_char_in", e_char_in, 0);
                chk("a_step", e_new_char, 1);
            end
            ok = bus.out_valid;
        end
        chk("a_latency", n, 4);
        chk("a_range", (bus.out_data > 8'h41 && bus.out_data <= 8'h5A), 1);
        wait_idle();
        chk("a_nc_once", nc_cyc - nc0, 1);
        chk("a_cnt", char_count, 1);

        cfg_load(15'd0, 2'd0, 2'd1, 2'd2);
        cap.delete();
        for (int i = 0; i < 5; i++) send(8'(hello.getc(i)));
        wait_idle();
        for (int i = 0; i < 5; i++) ct[i] = (cap.size() > i) ? cap[i] : 8'h00;
        cfg_load(15'd0, 2'd0, 2'd1, 2'd2);
        cap.delete();
        for (int i = 0; i < 5; i++) send(ct[i]);
        wait_idle();
        for (int i = 0; i < 5; i++)
            chk("rt_char", (cap.size() > i) ? 32'(cap[i]) : 32'hFFFF,
                32'(hello.getc(i)));
        chk("rt_cnt", char_count, 5);

        lk0 = lk_cyc; ce0 = ce_cyc;
        cfg_load(15'd0, 2'd0, 2'd3, 2'd2);
        chk("bad_rb_err", ce_cyc - ce0, 1);
        chk("bad_rb_keep", e_rB_cfg, 1);
        chk("bad_rb_noload", lk_cyc - lk0, 0);
        ce0 = ce_cyc;
        cfg_load({5'd0, 5'd0, 5'd26}, 2'd1, 2'd1, 2'd2);
        chk("bad_key_err", ce_cyc - ce0, 1);
        chk("bad_key_ra", e_rA_cfg, 0);
        chk("bad_key_cnt", char_count, 5);

        nc0 = nc_cyc; cc0 = int'(char_count);
        send(8'h20);
        wait_idle();
        chk("sp_nostep", nc_cyc - nc0, 0);
        chk("sp_cnt", char_count, cc0);

        bus.out_ready = 0;
        send(8'h5A);
        n = 0; ok = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            ok = bus.out_valid;
        end
        ir = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.in_ready) ir++;
        end
        chk("stall_ov", bus.out_valid, 1);
        chk("stall_ir", ir, 0);
        chk("stall_stable", unstable, 0);
        @(posedge clk); #1;
        bus.out_ready = 1;
        wait_idle();

        bus.in_valid = 1; bus.in_data = 8'h51;
        bus.cfg_key = {5'd3, 5'd7, 5'd11};
        bus.cfg_rA = 2'd2; bus.cfg_rB = 2'd0; bus.cfg_rC = 2'd1;
        bus.cfg_valid = 1;
        @(negedge clk);
        chk("both_cfg_rdy", bus.cfg_ready, 1);
        chk("both_in_rdy", bus.in_ready, 0);
        sb_cfg({5'd3, 5'd7, 5'd11}, 2'd2, 2'd0, 2'd1);
        @(posedge clk); #1;
        bus.cfg_valid = 0;
        send(8'h51);
        wait_idle();
        chk("both_key", e_key, {5'd3, 5'd7, 5'd11});
        chk("both_ra", e_rA_cfg, 2);

        bus.out_ready = 0;
        send(8'h42);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1;
        sbq.delete();
        no0 = n_out;
        @(posedge clk); #1;
        reset = 0;
        chk("abort_ov", bus.out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rb", e_rB_cfg, 1);
        bus.in_valid = 1; bus.in_data = 8'h43;
        ir = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.in_ready) ir++;
        end
        chk("abort_ir", ir, 0);
        @(posedge clk); #1;
        bus.in_valid = 0;
        bus.out_ready = 1;
        cyc(3);
        chk("abort_noout", n_out - no0, 0);

        bus2.cfg_valid = 1;
        @(posedge clk); #1;
        bus2.cfg_valid = 0;
        cyc(2);
        bus2.in_valid = 1; bus2.in_data = 8'h20;
        @(negedge clk);
        chk("p0_acc", bus2.in_ready, 1);
        @(posedge clk); #1;
        bus2.in_valid = 0;
        cyc(10);
        chk("p0_cherr", ce2, 1);
        chk("p0_noout", ov2, 0);
        chk("p0_nostep", nc2, 0);
        chk("p0_idle", c2_busy, 0);

        chk("strobe_overlap", overlap, 0);
        chk("strobe_width", wide, 0);
        chk("sb_left", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
